// File: rtl/uart_echo_ctrl.sv
// Echo path between uart_rx and uart_tx: buffers received bytes in a small FIFO
// and replays each one to uart_tx, paced by tx_busy, while tracking error/overflow status.
module uart_echo_ctrl #(
  parameter int DEPTH_LOG2   = 3,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  rx_parity_err,
  input  logic                  rx_frame_err,
  input  logic                  drop_err_en,
  input  logic                  clr_status,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic                  overflow,
  output logic [7:0]            err_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] data;
    logic       err;
  } rx_req_t;

  state_t                state, state_nxt;
  rx_req_t               req;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [TW-1:0]         to_cnt;
  logic                  keep, full, pop, push, ovf_evt, err_evt;

  assign req.vld  = rx_valid;
  assign req.data = rx_data;
  assign req.err  = rx_parity_err | rx_frame_err;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign keep    = req.vld & ~(drop_err_en & req.err);
  assign full    = (fifo_count == (DEPTH_LOG2+1)'(DEPTH));
  assign pop     = (state == IDLE) & (fifo_count != '0) & ~tx_busy;
  assign push    = keep & (~full | pop);
  assign ovf_evt = keep & full & ~pop;
  assign err_evt = req.vld & req.err;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req.data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) tx_data <= 8'h00;
    else if (pop) tx_data <= mem[rd_ptr];
  end

  // New events take priority over a coincident clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow  <= 1'b0;
      err_count <= 8'h00;
    end else begin
      if (ovf_evt)         overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;

      if (err_evt) begin
        if (clr_status)              err_count <= 8'h01;
        else if (err_count != 8'hFF) err_count <= err_count + 8'h01;
      end else if (clr_status) begin
        err_count <= 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                   to_cnt <= '0;
    else if (state == START)     to_cnt <= '0;
    else if (state == WAIT_BUSY) to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // WAIT_BUSY lasts at most BUSY_TIMEOUT cycles; a timed-out byte is treated as sent.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pop) state_nxt = START;
      START:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)                                state_nxt = WAIT_DONE;
        else if (to_cnt == TW'(BUSY_TIMEOUT - 1))   state_nxt = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_start = (state == START);
  end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Directed bench for uart_echo_ctrl: a tx_busy model, an echo monitor and one task per scenario.
module tb_uart_echo_ctrl;
  localparam int DEPTH_LOG2   = 3;
  localparam int BUSY_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       rx_valid, rx_parity_err, rx_frame_err, drop_err_en, clr_status, tx_busy;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [DEPTH_LOG2:0] fifo_count;
  logic       overflow;
  logic [7:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  // busy_mode: 0 = busy for busy_len cycles after each tx_start, 1 = stuck high,
  // 2 = stuck low, 3 = driven directly by the test task
  int busy_mode = 2;
  int busy_len  = 10;
  int cyc = 0;
  int peak = 0;
  logic [7:0] echo_q[$];
  int         start_cyc[$];

  uart_echo_ctrl #(.DEPTH_LOG2(DEPTH_LOG2), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .drop_err_en(drop_err_en), .clr_status(clr_status), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .fifo_count(fifo_count),
    .overflow(overflow), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_mode == 1) tx_busy = 1'b1;
      else if (busy_mode == 0 && tx_start === 1'b1) begin
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
      end else if (busy_mode != 3) tx_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rstn === 1'b1 && tx_start === 1'b1) begin
      echo_q.push_back(tx_data);
      start_cyc.push_back(cyc);
    end
    if (int'(fifo_count) > peak) peak = int'(fifo_count);
  end

  task automatic push_byte(input logic [7:0] d, input logic pe, input logic fe);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d; rx_parity_err = pe; rx_frame_err = fe;
  endtask

  task automatic rx_idle();
    @(negedge clk);
    rx_valid = 1'b0; rx_parity_err = 1'b0; rx_frame_err = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_echoes(input int n, input int budget);
    int k = 0;
    while (echo_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if (echo_q.size() < n) begin
      miscompares++;
      $display("FAIL wait_echoes: got %0d echoes, need %0d within %0d cycles", echo_q.size(), n, budget);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rx_parity_err = 1'b0;
    rx_frame_err = 1'b0; drop_err_en = 1'b0; clr_status = 1'b0;
    #3;
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_tx_start: got %b exp 0", tx_start); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx_data: got %h exp 00", tx_data); end
    vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL reset_fifo_count: got %0d exp 0", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b exp 0", overflow); end
    vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL reset_err_count: got %0d exp 0", err_count); end
    settle(2);
    rstn = 1'b1;
    settle(2);
  endtask

  task automatic test_single_echo();
    busy_mode = 0; busy_len = 10;
    echo_q.delete(); start_cyc.delete();
    push_byte(8'hA5, 1'b0, 1'b0);
    rx_idle();
    vectors++; if (fifo_count !== 4'd1) begin miscompares++; $display("FAIL single_count1: got %0d exp 1", fifo_count); end
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL single_early_start: got %b exp 0", tx_start); end
    settle(1);
    vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL single_start_latency: got %b exp 1", tx_start); end
    vectors++; if (tx_data !== 8'hA5) begin miscompares++; $display("FAIL single_tx_data: got %h exp a5", tx_data); end
    vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL single_count0: got %0d exp 0", fifo_count); end
    settle(30);
    vectors++; if (echo_q.size() !== 1) begin miscompares++; $display("FAIL single_echo_count: got %0d exp 1", echo_q.size()); end
    vectors++; if (err_count !== 8'h00) begin miscompares++; $display("FAIL single_err_count: got %0d exp 0", err_count); end
  endtask

  task automatic test_burst();
    busy_mode = 0; busy_len = 20;
    echo_q.delete(); peak = 0;
    for (int i = 1; i <= 5; i++) push_byte(8'(i), 1'b0, 1'b0);
    rx_idle();
    wait_echoes(5, 300);
    settle(30);
    vectors++; if (echo_q.size() !== 5) begin miscompares++; $display("FAIL burst_echo_count: got %0d exp 5", echo_q.size()); end
    for (int i = 0; i < 5 && i < echo_q.size(); i++) begin
      vectors++;
      if (echo_q[i] !== 8'(i + 1)) begin miscompares++; $display("FAIL burst_order[%0d]: got %h exp %h", i, echo_q[i], 8'(i + 1)); end
    end
    vectors++; if (peak < 4 || peak > 5) begin miscompares++; $display("FAIL burst_peak: got %0d exp 4..5", peak); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL burst_overflow: got %b exp 0", overflow); end
  endtask

  task automatic test_overflow();
    busy_mode = 1;
    settle(2);
    echo_q.delete();
    for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    rx_idle();
    vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL ovf_count: got %0d exp 8", fifo_count); end
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b exp 1", overflow); end
    busy_len = 3; busy_mode = 0;
    wait_echoes(8, 200);
    settle(30);
    vectors++; if (echo_q.size() !== 8) begin miscompares++; $display("FAIL ovf_echo_count: got %0d exp 8", echo_q.size()); end
    for (int i = 0; i < 8 && i < echo_q.size(); i++) begin
      vectors++;
      if (echo_q[i] !== 8'h10 + 8'(i)) begin miscompares++; $display("FAIL ovf_order[%0d]: got %h exp %h", i, echo_q[i], 8'h10 + 8'(i)); end
    end
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_clear: got %b exp 0", overflow); end
  endtask

  task automatic test_err_filter();
    busy_mode = 0; busy_len = 3;
    echo_q.delete();
    drop_err_en = 1'b1;
    push_byte(8'h33, 1'b1, 1'b0);
    push_byte(8'h44, 1'b0, 1'b0);
    rx_idle();
    settle(40);
    vectors++; if (echo_q.size() !== 1) begin miscompares++; $display("FAIL drop_echo_count: got %0d exp 1", echo_q.size()); end
    if (echo_q.size() > 0) begin
      vectors++; if (echo_q[0] !== 8'h44) begin miscompares++; $display("FAIL drop_echo_data: got %h exp 44", echo_q[0]); end
    end
    vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL drop_err_count: got %0d exp 1", err_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL drop_no_overflow: got %b exp 0", overflow); end

    echo_q.delete();
    drop_err_en = 1'b0;
    push_byte(8'h33, 1'b1, 1'b0);
    push_byte(8'h44, 1'b0, 1'b0);
    rx_idle();
    wait_echoes(2, 100);
    settle(20);
    vectors++; if (echo_q.size() !== 2) begin miscompares++; $display("FAIL keep_echo_count: got %0d exp 2", echo_q.size()); end
    if (echo_q.size() >= 2) begin
      vectors++; if (echo_q[0] !== 8'h33) begin miscompares++; $display("FAIL keep_echo0: got %h exp 33", echo_q[0]); end
      vectors++; if (echo_q[1] !== 8'h44) begin miscompares++; $display("FAIL keep_echo1: got %h exp 44", echo_q[1]); end
    end
    vectors++; if (err_count !== 8'd2) begin miscompares++; $display("FAIL keep_err_count: got %0d exp 2", err_count); end

    drop_err_en = 1'b1;
    for (int i = 0; i < 300; i++) push_byte(8'(i), i[0], ~i[0]);
    rx_idle();
    vectors++; if (err_count !== 8'd255) begin miscompares++; $display("FAIL err_saturate: got %0d exp 255", err_count); end
    vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL err_dropped_count: got %0d exp 0", fifo_count); end

    @(negedge clk);
    clr_status = 1'b1; rx_valid = 1'b1; rx_data = 8'h99; rx_frame_err = 1'b1;
    @(negedge clk);
    clr_status = 1'b0; rx_valid = 1'b0; rx_frame_err = 1'b0;
    vectors++; if (err_count !== 8'd1) begin miscompares++; $display("FAIL clr_vs_err: got %0d exp 1", err_count); end
    @(negedge clk); clr_status = 1'b1;
    @(negedge clk); clr_status = 1'b0;
    vectors++; if (err_count !== 8'd0) begin miscompares++; $display("FAIL clr_err: got %0d exp 0", err_count); end
    drop_err_en = 1'b0;
  endtask

  task automatic test_full_push_pop();
    busy_mode = 1;
    settle(2);
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i), 1'b0, 1'b0);
    rx_idle();
    vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL fpp_full: got %0d exp 8", fifo_count); end
    busy_mode = 3;
    settle(1);
    echo_q.delete();
    @(negedge clk);
    tx_busy = 1'b0; rx_valid = 1'b1; rx_data = 8'h28;
    @(negedge clk);
    rx_valid = 1'b0;
    vectors++; if (fifo_count !== 4'd8) begin miscompares++; $display("FAIL fpp_count: got %0d exp 8", fifo_count); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL fpp_overflow: got %b exp 0", overflow); end
    vectors++; if (tx_start !== 1'b1) begin miscompares++; $display("FAIL fpp_start: got %b exp 1", tx_start); end
    tx_busy = 1'b1;
    busy_len = 3; busy_mode = 0;
    wait_echoes(9, 200);
    settle(20);
    for (int i = 0; i < 9 && i < echo_q.size(); i++) begin
      vectors++;
      if (echo_q[i] !== 8'h20 + 8'(i)) begin miscompares++; $display("FAIL fpp_order[%0d]: got %h exp %h", i, echo_q[i], 8'h20 + 8'(i)); end
    end
  endtask

  task automatic test_timeout();
    busy_mode = 2;
    settle(2);
    echo_q.delete(); start_cyc.delete();
    push_byte(8'h61, 1'b0, 1'b0);
    push_byte(8'h62, 1'b0, 1'b0);
    rx_idle();
    wait_echoes(2, 50);
    settle(10);
    if (echo_q.size() >= 2) begin
      // START, BUSY_TIMEOUT WAIT_BUSY cycles, one IDLE pop cycle, then the next START
      vectors++;
      if (start_cyc[1] - start_cyc[0] !== BUSY_TIMEOUT + 2) begin
        miscompares++; $display("FAIL timeout_gap: got %0d exp %0d", start_cyc[1] - start_cyc[0], BUSY_TIMEOUT + 2);
      end
      vectors++; if (echo_q[1] !== 8'h62) begin miscompares++; $display("FAIL timeout_second: got %h exp 62", echo_q[1]); end
    end
    vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL timeout_drain: got %0d exp 0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    busy_mode = 0; busy_len = 10;
    echo_q.delete();
    push_byte(8'h71, 1'b0, 1'b0);
    push_byte(8'h72, 1'b0, 1'b0);
    push_byte(8'h73, 1'b0, 1'b0);
    rx_idle();
    wait_echoes(1, 20);
    settle(3);
    vectors++; if (fifo_count !== 4'd2) begin miscompares++; $display("FAIL mid_pre_count: got %0d exp 2", fifo_count); end
    rstn = 1'b0;
    #1;
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL mid_rst_start: got %b exp 0", tx_start); end
    vectors++; if (fifo_count !== 4'd0) begin miscompares++; $display("FAIL mid_rst_count: got %0d exp 0", fifo_count); end
    settle(2);
    rstn = 1'b1;
    echo_q.delete();
    settle(40);
    vectors++; if (echo_q.size() !== 0) begin miscompares++; $display("FAIL mid_no_echo: got %0d exp 0", echo_q.size()); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL mid_tx_data: got %h exp 00", tx_data); end
  endtask

  initial begin
    test_reset();
    test_single_echo();
    test_burst();
    test_overflow();
    test_err_filter();
    test_full_push_pop();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
